rr_arbiter_fsm: RTL and testbench

RR_ARBITER_FSM -- requirements
Module: rr_arbiter_fsm

---
 rtl/arb_pkg.sv | 6 +
 rtl/rr_pick.sv | 29 ++
 rtl/rr_arbiter_fsm.sv | 71 +++++++
 tb/tb_rr_arbiter_fsm.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// arb_pkg: shared state encoding and default sizing for the round-robin arbiter
package arb_pkg;
    typedef enum logic [1:0] {IDLE, GRANT, RELEASE} arb_state_t;
    localparam int ARB_N = 4;
    localparam int ARB_MAX_HOLD = 8;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: picks the first set request scanning upward from last_id+1, wrapping
module rr_pick
    import arb_pkg::*;
#(
    parameter int N = ARB_N,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_id,
    output logic          found,
    output logic [IW-1:0] pick_id
);
    logic [IW:0] s;

    // scan from farthest to nearest so the nearest candidate wins
    always_comb begin
        found = 1'b0;
        pick_id = '0;
        s = '0;
        for (int k = N; k >= 1; k--) begin
            s = {1'b0, last_id} + (IW+1)'(k);
            s = s >= (IW+1)'(N) ? s - (IW+1)'(N) : s;
            if (req[s[IW-1:0]]) begin
                found = 1'b1;
                pick_id = s[IW-1:0];
            end
        end
    end
endmodule

// File: rtl/rr_arbiter_fsm.sv
// rr_arbiter_fsm: round-robin arbiter with bounded tenure and a one-cycle release state
module rr_arbiter_fsm
    import arb_pkg::*;
#(
    parameter int N = ARB_N,
    parameter int MAX_HOLD = ARB_MAX_HOLD,
    localparam int IW = $clog2(N),
    localparam int HW = $clog2(MAX_HOLD)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  grant,
    output logic          grant_valid,
    output logic [IW-1:0] grant_id,
    output logic          timeout
);
    arb_state_t state, state_next;
    logic [HW-1:0] hold_cnt;
    logic [IW-1:0] last_id, pick_id;
    logic found, owner_req, at_limit;

    rr_pick #(.N(N)) u_pick (
        .req(req),
        .last_id(last_id),
        .found(found),
        .pick_id(pick_id)
    );

    assign owner_req = req[grant_id];
    assign at_limit = hold_cnt == HW'(MAX_HOLD - 1);
    assign timeout = state == GRANT && owner_req && at_limit;

    always_comb begin
        state_next = state == IDLE  ? (found ? GRANT : IDLE) :
                     state == GRANT ? ((!owner_req || at_limit) ? RELEASE : GRANT) :
                     IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else state <= state_next;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) hold_cnt <= '0;
        else hold_cnt <= (state == GRANT && state_next == GRANT) ? hold_cnt + HW'(1) : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) last_id <= IW'(N - 1);
        else if (state == GRANT && state_next != GRANT) last_id <= grant_id;
    end

    // grant outputs are loaded on entry to GRANT and cleared on any exit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grant <= '0;
            grant_valid <= 1'b0;
            grant_id <= '0;
        end else if (state == IDLE && found) begin
            grant <= N'(1) << pick_id;
            grant_valid <= 1'b1;
            grant_id <= pick_id;
        end else if (state_next != GRANT) begin
            grant <= '0;
            grant_valid <= 1'b0;
            grant_id <= '0;
        end
    end
endmodule

// File: tb/tb_rr_arbiter_fsm.sv
// tb_rr_arbiter_fsm: ownership/cooldown model checked every cycle plus pinned literal expectations
module tb_rr_arbiter_fsm;
    localparam int NR = 4;
    localparam int MH = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [NR-1:0] req = '0;
    logic [NR-1:0] grant;
    logic grant_valid;
    logic [1:0] grant_id;
    logic timeout;

    int checks = 0;
    int errors = 0;
    int m_owner, m_held, m_cool, m_last;

    rr_arbiter_fsm #(.N(NR), .MAX_HOLD(MH)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .req(req),
        .grant(grant),
        .grant_valid(grant_valid),
        .grant_id(grant_id),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int req_bit(input int i);
        return (int'(req) >> i) & 1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_held = 0;
        m_cool = 0;
        m_last = NR - 1;
    endtask

    // owner keeps the resource until it drops req or uses MH cycles; then one dead cycle before re-arbitration
    task automatic model_step();
        if (m_owner >= 0) begin
            if (req_bit(m_owner) == 0 || m_held == MH - 1) begin
                m_last = m_owner;
                m_owner = -1;
                m_cool = 1;
            end else m_held++;
        end else if (m_cool > 0) m_cool--;
        else
            for (int k = 1; k <= NR; k++)
                if (m_owner < 0 && req_bit((m_last + k) % NR) == 1) begin
                    m_owner = (m_last + k) % NR;
                    m_held = 0;
                end
    endtask

    task automatic tick();
        @(negedge clk);
        chk("grant", int'(grant), m_owner >= 0 ? (1 << m_owner) : 0);
        chk("grant_valid", int'(grant_valid), m_owner >= 0 ? 1 : 0);
        chk("grant_id", int'(grant_id), m_owner >= 0 ? m_owner : 0);
        chk("timeout", int'(timeout), (m_owner >= 0 && req_bit(m_owner) == 1 && m_held == MH - 1) ? 1 : 0);
        @(posedge clk);
        if (!reset_n) model_reset();
        else model_step();
        #1;
    endtask

    task automatic drive(input logic [NR-1:0] r);
        req = r;
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req = '0;
        model_reset();
        #1;
        chk("rst_grant", int'(grant), 0);
        chk("rst_valid", int'(grant_valid), 0);
        chk("rst_id", int'(grant_id), 0);
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    logic [NR-1:0] tbl [12] = '{4'b1010, 4'b0110, 4'b1111, 4'b0000, 4'b1000, 4'b0011,
                                4'b1100, 4'b0101, 4'b1111, 4'b1111, 4'b0001, 4'b0000};

    initial begin
        model_reset();
        @(posedge clk);
        #1;
        do_reset();
        drive(4'b0000);
        repeat (10) tick();
        chk("idle_grant", int'(grant), 0);

        do_reset();
        drive(4'b0001);
        tick();
        chk("single_c1", int'(grant), 1);
        repeat (2) tick();
        drive(4'b0000);
        chk("single_c3", int'(grant), 1);
        tick();
        chk("single_c4", int'(grant), 0);
        tick();
        chk("single_c5", int'(grant), 0);

        do_reset();
        for (int c = 0; c < 42; c++) begin
            drive(4'b1111);
            if (c == 1) chk("rot_c1", int'(grant), 1);
            if (c == 7) chk("rot_to_c7", int'(timeout), 0);
            if (c == 8) chk("rot_to_c8", int'(timeout), 1);
            if (c == 9) chk("rot_c9", int'(grant), 0);
            if (c == 10) chk("rot_c10", int'(grant), 0);
            if (c == 11) chk("rot_c11", int'(grant), 2);
            if (c == 18) chk("rot_to_c18", int'(timeout), 1);
            if (c == 21) chk("rot_c21", int'(grant), 4);
            if (c == 31) chk("rot_c31", int'(grant), 8);
            if (c == 41) chk("rot_c41", int'(grant), 1);
            tick();
        end

        do_reset();
        drive(4'b0010);
        repeat (3) tick();
        chk("skip_id1", int'(grant), 2);
        drive(4'b0000);
        tick();
        drive(4'b0101);
        repeat (2) tick();
        chk("skip_next", int'(grant), 4);
        chk("skip_next_id", int'(grant_id), 2);
        drive(4'b0001);
        repeat (3) tick();
        chk("skip_wrap", int'(grant), 1);

        do_reset();
        drive(4'b0100);
        repeat (3) tick();
        chk("mid_own", int'(grant), 4);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_grant", int'(grant), 0);
        chk("mid_rst_valid", int'(grant_valid), 0);
        chk("mid_rst_id", int'(grant_id), 0);
        model_reset();
        repeat (2) tick();
        reset_n = 1'b1;
        drive(4'b1001);
        tick();
        chk("mid_after", int'(grant), 1);

        do_reset();
        drive(4'b0001);
        repeat (8) tick();
        drive(4'b0000);
        chk("drop_last_grant", int'(grant), 1);
        chk("drop_last_to", int'(timeout), 0);
        tick();
        chk("drop_release", int'(grant), 0);
        drive(4'b0011);
        repeat (2) tick();
        chk("drop_next", int'(grant), 2);

        do_reset();
        foreach (tbl[i]) begin
            drive(tbl[i]);
            repeat (5) tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
